// File: rtl/nibble_serial_addsub.sv
// ---------------------------------------------------------------------------
// nibble_serial_addsub
//   Multi-precision add/subtract sequencer. A single 4-bit add/sub slice
//   (adder4sub) is reused once per cycle, LSB nibble first. The carry is
//   chained between cycles through a register, so a W = 4*NIBBLES bit result
//   needs no extra adder hardware.
//
// Ports
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous, active-high reset (priority over start)
//   start      in  1  request; accepted only while busy = 0
//   sub        in  1  0: A+B, 1: A-B (sampled with start)
//   a_in       in  W  operand A (sampled with start)
//   b_in       in  W  operand B (sampled with start)
//   busy       out 1  high while an operation is in progress
//   done       out 1  one-cycle pulse; result/carry_out/overflow updated
//   result     out W  sum/difference mod 2^W, held until the next done
//   carry_out  out 1  final carry; for sub, 1 means no borrow (A >= B)
//   overflow   out 1  two's-complement overflow of the W-bit operation
// ---------------------------------------------------------------------------

// 4-bit ripple add/sub slice. The stage-0 carry-in is tied to m and b is
// inverted when m = 1, so the slice computes a + (b ^ {4{m}}) + m.
// The c_in pin exists on the slice but does not affect the sum.
module adder4sub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [4:0] c;
    logic [3:0] bx;

    always_comb begin
        bx   = b ^ {4{m}};
        // (c_in & m) is absorbed by m: the pin is present but inert.
        c    = '0;
        c[0] = m | (c_in & m);
        s    = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ bx[i] ^ c[i];
            c[i + 1] = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
        end
        c_out = c[4];
    end
endmodule

module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow
);
    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;
    logic [W-1:0]       result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;

    // Operand/accumulator storage carries no reset: only control is reset.
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               sub_q, sub_d;
    logic [W-5:0]       acc_q, acc_d;

    logic [3:0]         a_nib, b_nib, y_nib, s_nib;
    logic               s_cout;

    // Current nibble select and slice drive. Feeding y ^ {4{c}} with m = c
    // makes the slice add y plus an arbitrary carry c.
    always_comb begin
        a_nib = a_q[{cnt_q, 2'b00} +: 4];
        b_nib = b_q[{cnt_q, 2'b00} +: 4];
        y_nib = sub_q ? ~b_nib : b_nib;
    end

    adder4sub u_slice (
        .a     (a_nib),
        .b     (y_nib ^ {4{carry_q}}),
        .m     (carry_q),
        .c_in  (1'b0),
        .s     (s_nib),
        .c_out (s_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        done_d      = 1'b0;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        acc_d       = acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    sub_d   = sub;
                    cnt_d   = '0;
                    carry_d = sub;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = s_cout;
                if (cnt_q == LAST) begin
                    result_d    = {s_nib, acc_q};
                    carry_out_d = s_cout;
                    // Signed overflow: same-sign addends, sum sign differs.
                    overflow_d  = (a_nib[3] == y_nib[3]) && (s_nib[3] != a_nib[3]);
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    acc_d[{cnt_q, 2'b00} +: 4] = s_nib;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            done_q      <= done_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sub_q <= sub_d;
        acc_q <= acc_d;
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
endmodule
